cache_fill_arbiter: RTL and testbench

//  Shares the single unified multi-cycle main memory between the I-cache and D-cache miss paths of
//  the 5-stage pipeline. Grants one requester at a time, streams 8-word block fills from memory into
//  the owning cache's data array, and issues single-word D-cache write-through stores.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_fill_arbiter_fill_word_counter.sv | 41 ++++
 rtl/cache_fill_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int WORD_IDX_W = 3;   // 8 words per block

    // Clears the byte-in-block bits to get the 16-byte block base.
    localparam logic [ADDR_W-1:0] BLK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// Word-index counter for one side (issue or receive) of a block fill.
// Latency: count updates at the clock edge after inc; tc is combinational from the count.
// Backpressure: none; holds at the terminal count instead of wrapping.
//
// Ports: clk/rst (sync active-high), clr (return to 0, wins over inc),
//        inc (advance by one), cnt (current word index), tc (cnt is the last word).
module fill_word_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] cnt,
    output logic                  tc
);

    logic [WORD_IDX_W-1:0] cnt_q;
    logic [WORD_IDX_W-1:0] cnt_d;

    assign tc  = (cnt_q == '1);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto one memory port.
// Latency: grant at the edge after the request; fill addresses cycles 1..8, done with the 8th word.
// Backpressure: none toward memory; requesters hold their level request until their done pulse.
//
// Ports: ic_miss/ic_miss_addr, dc_miss/dc_miss_addr, dc_wr_req/dc_wr_addr/dc_wr_data  requests in;
//        mem_en/mem_wr/mem_addr/mem_wdata  memory command out; mem_rdata/mem_rvalid  memory return in;
//        fill_data/fill_word + {ic,dc}_fill_we/_tag_we/_done  cache array writes; busy = not idle.
module cache_fill_arbiter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_miss,
    input  logic [ADDR_W-1:0]     ic_miss_addr,
    input  logic                  dc_miss,
    input  logic [ADDR_W-1:0]     dc_miss_addr,
    input  logic                  dc_wr_req,
    input  logic [ADDR_W-1:0]     dc_wr_addr,
    input  logic [DATA_W-1:0]     dc_wr_data,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  ic_fill_we,
    output logic                  ic_tag_we,
    output logic                  ic_done,
    output logic                  dc_fill_we,
    output logic                  dc_tag_we,
    output logic                  dc_done,
    output logic                  busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                issue_done_q, issue_done_d;   // all 8 addresses sent

    logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt;
    logic                  issue_tc, recv_tc;

    logic in_fill, issue_inc, recv_inc, fill_last, op_end, arb_en;
    logic wr_req_m, dc_miss_m, ic_miss_m;

    assign in_fill   = (state_q == I_FILL) || (state_q == D_FILL);
    assign issue_inc = in_fill && !issue_done_q;
    assign recv_inc  = in_fill && mem_rvalid;
    assign fill_last = recv_inc && recv_tc;
    assign op_end    = fill_last || (state_q == D_WRITE);

    // Arbitration runs in IDLE and also in the completion cycle, so a waiting
    // request is granted at the edge that ends the done cycle. The requester
    // being completed still holds its level that cycle, so it is masked out.
    assign arb_en    = (state_q == IDLE) || op_end;
    assign wr_req_m  = dc_wr_req && (state_q != D_WRITE);
    assign dc_miss_m = dc_miss   && (state_q != D_FILL);
    assign ic_miss_m = ic_miss   && (state_q != I_FILL);

    fill_word_counter u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (op_end),
        .inc (issue_inc),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    fill_word_counter u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (op_end),
        .inc (recv_inc),
        .cnt (recv_cnt),
        .tc  (recv_tc)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        issue_done_d = issue_done_q;

        if (issue_inc && issue_tc) begin
            issue_done_d = 1'b1;
        end
        if (op_end) begin
            state_d      = IDLE;
            issue_done_d = 1'b0;
        end
        if (arb_en) begin
            if (wr_req_m) begin
                state_d = D_WRITE;
                base_d  = dc_wr_addr;
                wdata_d = dc_wr_data;
            end else if (dc_miss_m) begin
                state_d = D_FILL;
                base_d  = dc_miss_addr & BLK_MASK;
            end else if (ic_miss_m) begin
                state_d = I_FILL;
                base_d  = ic_miss_addr & BLK_MASK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            wdata_q      <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Command outputs decode the registered state; fill strobes pass mem_rvalid
    // straight through so the word lands in the array the cycle it returns.
    // Everything is forced quiet while rst is high so an aborted fill cannot
    // write the arrays in the reset cycle.
    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_data  = '0;
        fill_word  = '0;
        ic_fill_we = 1'b0;
        ic_tag_we  = 1'b0;
        ic_done    = 1'b0;
        dc_fill_we = 1'b0;
        dc_tag_we  = 1'b0;
        dc_done    = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            busy      = (state_q != IDLE);
            fill_data = mem_rdata;
            if (state_q == D_WRITE) begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = base_q;
                mem_wdata = wdata_q;
                dc_done   = 1'b1;
            end
            if (issue_inc) begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'({issue_cnt, 1'b0});
            end
            if (recv_inc) begin
                fill_word  = recv_cnt;
                ic_fill_we = (state_q == I_FILL);
                dc_fill_we = (state_q == D_FILL);
            end
            if (fill_last) begin
                ic_tag_we = (state_q == I_FILL);
                ic_done   = (state_q == I_FILL);
                dc_tag_we = (state_q == D_FILL);
                dc_done   = (state_q == D_FILL);
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_miss = 1'b0;
    logic [15:0] ic_miss_addr = '0;
    logic        dc_miss = 1'b0;
    logic [15:0] dc_miss_addr = '0;
    logic        dc_wr_req = 1'b0;
    logic [15:0] dc_wr_addr = '0;
    logic [15:0] dc_wr_data = '0;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_word;
    logic        ic_fill_we, ic_tag_we, ic_done;
    logic        dc_fill_we, dc_tag_we, dc_done, busy;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_data(fill_data), .fill_word(fill_word),
        .ic_fill_we(ic_fill_we), .ic_tag_we(ic_tag_we), .ic_done(ic_done),
        .dc_fill_we(dc_fill_we), .dc_tag_we(dc_tag_we), .dc_done(dc_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory model: a read issued in cycle k returns in cycle k+4.
    logic [3:0]  rv_pipe = '0;
    logic [15:0] a_pipe [4];
    logic        stray_rv = 1'b0;
    initial for (int i = 0; i < 4; i++) a_pipe[i] = '0;

    always @(posedge clk) begin
        rv_pipe   <= {rv_pipe[2:0], mem_en && !mem_wr};
        a_pipe[0] <= mem_addr;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        a_pipe[3] <= a_pipe[2];
    end

    assign mem_rvalid = rv_pipe[3] | stray_rv;
    assign mem_rdata  = rv_pipe[3] ? memval(a_pipe[3]) : (stray_rv ? 16'hDEAD : 16'h0000);

    // Scoreboard queues
    typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; int cyc; } mem_exp_t;
    typedef struct { logic ic; logic [2:0] word; logic [15:0] data; int cyc; } fill_exp_t;
    typedef struct { logic ic; int cyc; } done_exp_t;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];
    done_exp_t exp_done[$];
    mem_exp_t  me;
    fill_exp_t fe;
    done_exp_t de;

    task automatic push_fill(input logic ic, input logic [15:0] base, input int t0);
        for (int i = 0; i < 8; i++) begin
            exp_mem.push_back('{1'b0, base + 16'(2 * i), 16'h0000, t0 + i});
            exp_fill.push_back('{ic, 3'(i), memval(base + 16'(2 * i)), t0 + 4 + i});
        end
        exp_done.push_back('{ic, t0 + 11});
    endtask

    task automatic push_write(input logic [15:0] a, input logic [15:0] d, input int t);
        exp_mem.push_back('{1'b1, a, d, t});
        exp_done.push_back('{1'b0, t});
    endtask

    // Monitor: sampled mid-cycle, every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (mem_en) begin
            if (exp_mem.size() == 0) chk("mem_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                me = exp_mem.pop_front();
                chk("mem_wr",    32'(mem_wr),    32'(me.wr));
                chk("mem_addr",  32'(mem_addr),  32'(me.addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
                chk("mem_cycle", 32'(cyc),       32'(me.cyc));
            end
        end
        if (!(mem_en && mem_wr)) chk("mem_wdata_zero", 32'(mem_wdata), 32'h0);
        if (ic_fill_we || dc_fill_we) begin
            chk("fill_owner_excl", 32'(ic_fill_we && dc_fill_we), 32'h0);
            if (exp_fill.size() == 0) chk("fill_unexpected", 32'(fill_word), 32'hFFFF_FFFF);
            else begin
                fe = exp_fill.pop_front();
                chk("fill_owner", 32'({ic_fill_we, dc_fill_we}), fe.ic ? 32'h2 : 32'h1);
                chk("fill_word",  32'(fill_word), 32'(fe.word));
                chk("fill_data",  32'(fill_data), 32'(fe.data));
                chk("fill_cycle", 32'(cyc),       32'(fe.cyc));
                chk("tag_we", 32'({ic_tag_we, dc_tag_we}),
                    (fe.word == 3'd7) ? (fe.ic ? 32'h2 : 32'h1) : 32'h0);
            end
        end else begin
            chk("tag_we_stray", 32'({ic_tag_we, dc_tag_we}), 32'h0);
        end
        if (ic_done || dc_done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 32'({ic_done, dc_done}), 32'h0);
            else begin
                de = exp_done.pop_front();
                chk("done_owner", 32'({ic_done, dc_done}), de.ic ? 32'h2 : 32'h1);
                chk("done_cycle", 32'(cyc), 32'(de.cyc));
            end
        end
    end

    task automatic run_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test(output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_mem_q"},  32'(exp_mem.size()),  32'h0);
        chk({tag, "_fill_q"}, 32'(exp_fill.size()), 32'h0);
        chk({tag, "_done_q"}, 32'(exp_done.size()), 32'h0);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    int c0;

    initial begin
        // Reset state
        run_until(3);
        @(negedge clk);
        chk("rst_ctrl", 32'({mem_en, mem_wr, ic_fill_we, ic_tag_we, ic_done,
                             dc_fill_we, dc_tag_we, dc_done, busy}), 32'h0);
        chk("rst_bus",  {mem_addr, mem_wdata}, 32'h0);
        chk("rst_fill", 32'({fill_data, fill_word}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // 1: single I fill from a mid-block address
        start_test(c0);
        ic_miss = 1'b1; ic_miss_addr = 16'h0036;
        push_fill(1'b1, 16'h0030, c0 + 1);
        run_until(c0 + 6);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'h1);
        run_until(c0 + 13);
        ic_miss = 1'b0;
        run_until(c0 + 15);
        check_drained("t1");

        // 2: all three requests at once -> store, D fill, I fill
        start_test(c0);
        dc_wr_req = 1'b1; dc_wr_addr = 16'h0100; dc_wr_data = 16'hBEEF;
        dc_miss = 1'b1;   dc_miss_addr = 16'h0208;
        ic_miss = 1'b1;   ic_miss_addr = 16'h0410;
        push_write(16'h0100, 16'hBEEF, c0 + 1);
        push_fill(1'b0, 16'h0200, c0 + 2);
        push_fill(1'b1, 16'h0410, c0 + 14);
        run_until(c0 + 2);
        dc_wr_req = 1'b0;
        run_until(c0 + 14);
        dc_miss = 1'b0;
        run_until(c0 + 26);
        ic_miss = 1'b0;
        run_until(c0 + 28);
        check_drained("t2");

        // 3: I miss arrives during a D fill and waits for dc_done
        start_test(c0);
        dc_miss = 1'b1; dc_miss_addr = 16'h0A5C;
        push_fill(1'b0, 16'h0A50, c0 + 1);
        run_until(c0 + 3);
        ic_miss = 1'b1; ic_miss_addr = 16'h1234;
        push_fill(1'b1, 16'h1230, c0 + 13);
        run_until(c0 + 13);
        dc_miss = 1'b0;
        run_until(c0 + 25);
        ic_miss = 1'b0;
        run_until(c0 + 27);
        check_drained("t3");

        // 4: reset in cycle 6 of a fill aborts it; late returns are dropped
        start_test(c0);
        ic_miss = 1'b1; ic_miss_addr = 16'h0070;
        for (int i = 0; i < 5; i++)
            exp_mem.push_back('{1'b0, 16'h0070 + 16'(2 * i), 16'h0000, c0 + 1 + i});
        exp_fill.push_back('{1'b1, 3'd0, memval(16'h0070), c0 + 5});
        run_until(c0 + 6);
        rst = 1'b1; ic_miss = 1'b0;
        run_until(c0 + 7);
        rst = 1'b0;
        for (int k = 7; k <= 12; k++) begin
            run_until(c0 + k);
            if (k == 10) stray_rv = 1'b1;
            @(negedge clk);
            chk("t4_quiet", 32'({ic_fill_we, ic_tag_we, ic_done, mem_en, busy}), 32'h0);
        end
        run_until(c0 + 13);
        stray_rv = 1'b0;
        check_drained("t4");

        // 5: I request dropped early; fill still completes with one done
        start_test(c0);
        ic_miss = 1'b1; ic_miss_addr = 16'h0088;
        push_fill(1'b1, 16'h0080, c0 + 1);
        run_until(c0 + 2);
        ic_miss = 1'b0;
        run_until(c0 + 15);
        check_drained("t5");

        // 6: stray rvalid while idle
        start_test(c0);
        stray_rv = 1'b1;
        @(negedge clk);
        chk("t6_no_we", 32'({ic_fill_we, dc_fill_we, ic_done, dc_done}), 32'h0);
        chk("t6_idle", 32'(busy), 32'h0);
        run_until(c0 + 1);
        stray_rv = 1'b0;
        run_until(c0 + 3);
        check_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
